// File: rtl/snapshot_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : snapshot_bank_if
// Brief    : Switch/button/LED bundle between lab board I/O and snapshot_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface snapshot_bank_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  switches;
    logic          retain;
    logic          capture;
    logic [1:0]    mode;
    logic [PW-1:0] sel;
    logic [N-1:0]  leds;
    logic [CW-1:0] count;
    logic          full;
    logic [PW-1:0] slot;

    modport master (
        output switches, retain, capture, mode, sel,
        input  leds, count, full, slot
    );

    modport slave (
        input  switches, retain, capture, mode, sel,
        output leds, count, full, slot
    );
endinterface
`default_nettype wire

// File: rtl/snapshot_bank.sv
`default_nettype none
// ============================================================================
// Module   : snapshot_bank
// Brief    : Live retain register plus a DEPTH-entry snapshot ring with
//            recall and timed playback onto the LED bank.
// Revision : 1.0 - initial release
// ============================================================================
module snapshot_bank #(
    parameter int N        = 8,
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               reset,
    snapshot_bank_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int XW = PW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [XW-1:0] DEPTH_X   = XW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [1:0] MODE_LIVE   = 2'b00;
    localparam logic [1:0] MODE_RECALL = 2'b01;
    localparam logic [1:0] MODE_PLAY   = 2'b10;

    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  bank_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] play_off_q, play_off_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          cap_q;

    logic          cap_edge;
    logic [XW-1:0] wr_ptr_inc;
    logic [XW-1:0] off_inc;
    logic [PW-1:0] oldest;
    logic [XW-1:0] play_sum;
    logic [PW-1:0] play_slot;

    always_comb begin
        cap_edge   = bus.capture & ~cap_q;
        q_d        = bus.retain ? q_q : bus.switches;
        wr_ptr_inc = {1'b0, wr_ptr_q} + XW'(1);
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (cap_edge) begin
            wr_ptr_d = (wr_ptr_inc == DEPTH_X) ? '0 : wr_ptr_inc[PW-1:0];
            if (count_q != DEPTH_C) begin
                count_d = count_q + CW'(1);
            end
        end

        // Wrap compares against the post-capture count so playback sees new entries at once.
        off_inc    = {1'b0, play_off_q} + XW'(1);
        tick_d     = '0;
        play_off_d = '0;
        if (bus.mode == MODE_PLAY) begin
            if (tick_q == TICK_LAST) begin
                play_off_d = (off_inc >= XW'(count_d)) ? '0 : off_inc[PW-1:0];
            end else begin
                tick_d     = tick_q + TW'(1);
                play_off_d = play_off_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            play_off_q <= '0;
            tick_q     <= '0;
            cap_q      <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            q_q        <= q_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            play_off_q <= play_off_d;
            tick_q     <= tick_d;
            cap_q      <= bus.capture;
            if (cap_edge) begin
                bank_q[wr_ptr_q] <= bus.switches;
            end
        end
    end

    always_comb begin
        oldest    = (count_q == DEPTH_C) ? wr_ptr_q : '0;
        play_sum  = {1'b0, oldest} + {1'b0, play_off_q};
        play_slot = (play_sum >= DEPTH_X) ? PW'(play_sum - DEPTH_X) : PW'(play_sum);

        bus.leds = q_q;
        bus.slot = '0;
        case (bus.mode)
            MODE_RECALL: begin
                bus.slot = bus.sel;
                bus.leds = ({1'b0, bus.sel} < DEPTH_X) ? bank_q[bus.sel] : '0;
            end
            MODE_PLAY: begin
                if (count_q == '0) begin
                    bus.leds = '0;
                end else begin
                    bus.slot = play_slot;
                    bus.leds = bank_q[play_slot];
                end
            end
            default: begin
                bus.leds = q_q;
                bus.slot = '0;
            end
        endcase
        bus.count = count_q;
        bus.full  = (count_q == DEPTH_C);
    end
endmodule
`default_nettype wire

// File: tb/tb_snapshot_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_snapshot_bank
// Brief    : Directed self-checking bench for snapshot_bank (N=8, DEPTH=4, TICK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snapshot_bank;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    snapshot_bank_if #(.N(8), .DEPTH(4)) bus ();

    snapshot_bank #(.N(8), .DEPTH(4), .TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] play_leds [4];
        logic [1:0] play_slot [4];
        play_leds[0] = 8'h02; play_leds[1] = 8'h03; play_leds[2] = 8'h04; play_leds[3] = 8'h05;
        play_slot[0] = 2'd1;  play_slot[1] = 2'd2;  play_slot[2] = 2'd3;  play_slot[3] = 2'd0;
        n_assert = 0;
        n_fail   = 0;

        // Reset with all switches high
        reset = 1'b1; bus.switches = 8'hFF; bus.retain = 1'b0; bus.capture = 1'b0;
        bus.mode = 2'b00; bus.sel = '0;
        step();
        check("rst_leds", 32'(bus.leds), 32'h00);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_slot", 32'(bus.slot), 32'd0);

        // Live load then retain
        reset = 1'b0; bus.switches = 8'hA5;
        step();
        check("live_load", 32'(bus.leds), 32'hA5);
        bus.retain = 1'b1; bus.switches = 8'h3C;
        step();
        check("retain_hold1", 32'(bus.leds), 32'hA5);
        step();
        check("retain_hold2", 32'(bus.leds), 32'hA5);

        // Held capture button writes once
        bus.retain = 1'b0; bus.switches = 8'h11; bus.capture = 1'b1;
        step();
        check("cap_first", 32'(bus.count), 32'd1);
        for (int i = 0; i < 9; i++) step();
        check("cap_held", 32'(bus.count), 32'd1);
        bus.mode = 2'b01; bus.sel = 2'd0; bus.capture = 1'b0;
        step();
        check("recall_11", 32'(bus.leds), 32'h11);

        // Button held across reset release
        bus.capture = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("cap_thru_rst_count", 32'(bus.count), 32'd0);
        check("cap_thru_rst_bank", 32'(bus.leds), 32'h00);
        bus.capture = 1'b0;
        step();

        // Ring overwrite with five captures
        for (int v = 1; v <= 5; v++) begin
            bus.switches = 8'(v); bus.capture = 1'b1;
            step();
            bus.capture = 1'b0;
            step();
        end
        check("ring_count", 32'(bus.count), 32'd4);
        check("ring_full", 32'(bus.full), 32'd1);
        bus.sel = 2'd0; #1;
        check("ring_sel0", 32'(bus.leds), 32'h05);
        bus.sel = 2'd1; #1;
        check("ring_sel1", 32'(bus.leds), 32'h02);
        check("ring_slot1", 32'(bus.slot), 32'd1);

        // Playback from oldest, 4 cycles per entry
        bus.mode = 2'b10; #1;
        check("play_start", 32'(bus.leds), 32'h02);
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("play_leds_k%0d", k), 32'(bus.leds), 32'(play_leds[(k / 4) % 4]));
            check($sformatf("play_slot_k%0d", k), 32'(bus.slot), 32'(play_slot[(k / 4) % 4]));
        end

        // Exit mid-interval then re-enter
        for (int i = 0; i < 5; i++) step();
        check("play_mid", 32'(bus.leds), 32'h03);
        bus.mode = 2'b00;
        step();
        check("exit_live", 32'(bus.leds), 32'h05);
        check("exit_slot", 32'(bus.slot), 32'd0);
        bus.mode = 2'b10; #1;
        check("reenter_now", 32'(bus.leds), 32'h02);
        for (int i = 0; i < 3; i++) step();
        check("reenter_3", 32'(bus.leds), 32'h02);
        step();
        check("reenter_4", 32'(bus.leds), 32'h03);

        // mode 11 acts as live
        bus.mode = 2'b11; bus.switches = 8'h5A;
        step();
        check("mode11_leds", 32'(bus.leds), 32'h5A);
        check("mode11_slot", 32'(bus.slot), 32'd0);

        // Empty playback
        reset = 1'b1;
        step();
        reset = 1'b0; bus.mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("empty_play_%0d", i), 32'(bus.leds), 32'h00);
        end
        check("empty_slot", 32'(bus.slot), 32'd0);
        bus.mode = 2'b00;
        step();

        // Partial fill captured during playback
        bus.mode = 2'b10; bus.switches = 8'hAA; bus.capture = 1'b1;
        step();
        check("part_e1", 32'(bus.leds), 32'hAA);
        check("part_count1", 32'(bus.count), 32'd1);
        bus.capture = 1'b0;
        step();
        bus.switches = 8'hBB; bus.capture = 1'b1;
        step();
        check("part_e3", 32'(bus.leds), 32'hAA);
        bus.capture = 1'b0;
        step();
        check("part_e4", 32'(bus.leds), 32'hBB);
        check("part_e4_slot", 32'(bus.slot), 32'd1);
        for (int i = 0; i < 3; i++) step();
        check("part_e7", 32'(bus.leds), 32'hBB);
        step();
        check("part_e8", 32'(bus.leds), 32'hAA);
        check("part_e8_slot", 32'(bus.slot), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("part_e12", 32'(bus.leds), 32'hBB);
        check("part_full", 32'(bus.full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
